// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
//   Frame controller for an external 10010 Moore sequence detector.
//   On an accepted start it latches a parallel frame, clears the detector for
//   one cycle, shifts the frame into the detector MSB-first (one bit per
//   clock), samples the detector output after every bit and counts matches.
//   Completion is flagged by a one-cycle done pulse.
//
//   Optional build macro: SEQ_DETECT_CTRL_MATCH_POS_EN
//     adds first_pos / first_vld (index of the bit that completed the first
//     match of the frame, 0 = MSB).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   start      in   frame request, sampled only in IDLE
//   data_in    in   [WIDTH] frame, latched on accepted start
//   busy       out  high in CLEAR, SHIFT, DRAIN and DONE
//   done       out  one-cycle completion pulse
//   match_cnt  out  [CNT_W] saturating match count of last/current frame
//   match_any  out  match_cnt != 0
//   det_clr    out  active-high clear to the detector
//   det_x      out  serial bit to the detector
//   det_z      in   detector Moore output
//   first_pos  out  [POS_W] first match position (macro builds only)
//   first_vld  out  first_pos is valid (macro builds only)
// ---------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned POS_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             match_any,
  output logic             det_clr,
  output logic             det_x,
  input  logic             det_z
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
  ,
  output logic [POS_W-1:0] first_pos,
  output logic             first_vld
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  // POS_W is guaranteed to hold WIDTH-1, so the bit counter shares its width
  // and the SHIFT-phase match position is simply bit_cnt-1.
  logic [POS_W-1:0] bit_cnt;
  logic             count_z;

  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // The z seen in the first SHIFT cycle belongs to the freshly cleared
  // detector; every later SHIFT cycle and DRAIN reports the previous bit.
  assign count_z = det_z & (((state == S_SHIFT) && (bit_cnt != '0)) ||
                            (state == S_DRAIN));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
      first_pos <= '0;
      first_vld <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg     <= data_in;
            bit_cnt   <= '0;
            match_cnt <= '0;
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
            first_pos <= '0;
            first_vld <= 1'b0;
`endif
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: state <= S_SHIFT;
        S_SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // count_z is never set in IDLE, so this cannot collide with the
      // start-time clear above.
      if (count_z && (match_cnt != CNT_MAX)) match_cnt <= match_cnt + 1'b1;
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
      if (count_z && !first_vld) begin
        first_vld <= 1'b1;
        first_pos <= (state == S_DRAIN) ? LAST_BIT : (bit_cnt - 1'b1);
      end
`endif
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign det_clr   = ~reset | (state == S_CLEAR);
  assign det_x     = (state == S_SHIFT) & shreg[WIDTH-1];
  assign match_any = |match_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
//   Self-checking bench: two controllers (CNT_W=5 and CNT_W=2) share the
//   stimulus, each driving its own behavioural 10010 Moore detector.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;

  logic       busy5, done5, any5, clr5, x5, z5;
  logic [4:0] cnt5;
  logic       busy2, done2, any2, clr2, x2, z2;
  logic [1:0] cnt2;
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
  logic [4:0] pos5, pos2;
  logic       vld5, vld2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.WIDTH(W), .CNT_W(5), .POS_W(5)) u5 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy5), .done(done5), .match_cnt(cnt5), .match_any(any5),
    .det_clr(clr5), .det_x(x5), .det_z(z5)
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
    , .first_pos(pos5), .first_vld(vld5)
`endif
  );

  seq_detect_ctrl #(.WIDTH(W), .CNT_W(2), .POS_W(5)) u2 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy2), .done(done2), .match_cnt(cnt2), .match_any(any2),
    .det_clr(clr2), .det_x(x2), .det_z(z2)
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
    , .first_pos(pos2), .first_vld(vld2)
`endif
  );

  // 10010 Moore detector, overlapping, synchronous active-high clear.
  // State k = length of longest matched prefix; 5 = full match (z=1).
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic x);
    case (s)
      3'd0:    det_next = x ? 3'd1 : 3'd0;
      3'd1:    det_next = x ? 3'd1 : 3'd2;
      3'd2:    det_next = x ? 3'd1 : 3'd3;
      3'd3:    det_next = x ? 3'd4 : 3'd0;
      3'd4:    det_next = x ? 3'd1 : 3'd5;
      default: det_next = x ? 3'd1 : 3'd3;
    endcase
  endfunction

  logic [2:0] ds5 = '0;
  logic [2:0] ds2 = '0;
  always @(posedge clk) ds5 <= clr5 ? 3'd0 : det_next(ds5, x5);
  always @(posedge clk) ds2 <= clr2 ? 3'd0 : det_next(ds2, x2);
  assign z5 = (ds5 == 3'd5);
  assign z2 = (ds2 == 3'd5);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    int           pos;
    logic         vld;
  } vec_t;

  vec_t vecs[7];

  task automatic check_results(input string tag, input int cnt, input int pos, input logic vld);
    int c2;
    c2 = (cnt > 3) ? 3 : cnt;
    chk({tag, " cnt5"}, 32'(cnt5), 32'(cnt));
    chk({tag, " any5"}, 32'(any5), 32'(cnt != 0));
    chk({tag, " cnt2"}, 32'(cnt2), 32'(c2));
    chk({tag, " any2"}, 32'(any2), 32'(cnt != 0));
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
    chk({tag, " vld5"}, 32'(vld5), 32'(vld));
    chk({tag, " pos5"}, 32'(pos5), 32'(pos));
    chk({tag, " vld2"}, 32'(vld2), 32'(vld));
    chk({tag, " pos2"}, 32'(pos2), 32'(pos));
`endif
  endtask

  // Entered in an idle cycle (cycle 0); leaves in cycle 20, which is idle.
  task automatic run_frame(input logic [W-1:0] d, input int cnt, input int pos, input logic vld);
    string tag;
    chk($sformatf("f%04h c0 busy", d), 32'(busy5), 32'd0);
    data_in = d;
    start   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        start   = 1'b0;
        data_in = ~d;
      end
      tag = $sformatf("f%04h c%0d", d, c);
      chk({tag, " busy"}, 32'(busy5), 32'(c <= 19));
      chk({tag, " done"}, 32'(done5), 32'(c == 19));
      chk({tag, " done2"}, 32'(done2), 32'(c == 19));
      chk({tag, " det_clr"}, 32'(clr5), 32'(c == 1));
      if (c >= 2 && c <= 17) chk({tag, " det_x"}, 32'(x5), 32'(d[W-1-(c-2)]));
      else                   chk({tag, " det_x"}, 32'(x5), 32'd0);
      if (c == 19 || c == 20) check_results(tag, cnt, pos, vld);
    end
  endtask

  initial begin
    vecs[0] = '{16'h9000, 1, 4,  1'b1};
    vecs[1] = '{16'h9248, 4, 4,  1'b1};
    vecs[2] = '{16'h0000, 0, 0,  1'b0};
    vecs[3] = '{16'hFFFF, 0, 0,  1'b0};
    vecs[4] = '{16'h4800, 1, 5,  1'b1};
    vecs[5] = '{16'h0012, 1, 15, 1'b1};
    vecs[6] = '{16'h9292, 4, 4,  1'b1};

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    chk("rst busy", 32'(busy5), 32'd0);
    chk("rst done", 32'(done5), 32'd0);
    chk("rst det_x", 32'(x5), 32'd0);
    chk("rst det_clr", 32'(clr5), 32'd1);
    chk("rst cnt", 32'(cnt5), 32'd0);
    chk("rst any", 32'(any5), 32'd0);
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
    chk("rst vld", 32'(vld5), 32'd0);
`endif
    reset = 1'b1;
    tick();
    chk("post-rst det_clr", 32'(clr5), 32'd0);

    // Table-driven frames, back to back
    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].data, vecs[i].cnt, vecs[i].pos, vecs[i].vld);

    // start in cycles 5 and 19 ignored; start in cycle 20 accepted
    data_in = 16'h9000;
    start   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk($sformatf("ign c%0d busy", c), 32'(busy5),
          32'((c <= 19) || (c >= 21 && c <= 39)));
      chk($sformatf("ign c%0d done", c), 32'(done5), 32'(c == 19 || c == 39));
      if (c == 19) check_results("ign c19", 1, 4, 1'b1);
      if (c == 39) check_results("ign c39", 4, 4, 1'b1);
      start   = (c == 5 || c == 19 || c == 20);
      data_in = (c == 5) ? 16'hFFFF : (c == 20) ? 16'h9248 : 16'h0000;
    end
    start = 1'b0;

    // Reset for one cycle in cycle 8 of frame 9240
    data_in = 16'h9240;
    start   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 8) begin
        chk("rmid c8 cnt before reset", 32'(cnt5), 32'd1);
        reset = 1'b0;
        #1;
        chk("rmid c8 det_clr", 32'(clr5), 32'd1);
        chk("rmid c8 det_clr2", 32'(clr2), 32'd1);
      end
      if (c == 9) begin
        reset = 1'b1;
        #1;
        chk("rmid c9 busy", 32'(busy5), 32'd0);
        chk("rmid c9 cnt", 32'(cnt5), 32'd0);
        chk("rmid c9 any", 32'(any5), 32'd0);
        chk("rmid c9 det_clr", 32'(clr5), 32'd0);
`ifdef SEQ_DETECT_CTRL_MATCH_POS_EN
        chk("rmid c9 vld", 32'(vld5), 32'd0);
`endif
      end
    end
    run_frame(16'h9000, 1, 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
